// File: rtl/pkt_sfifo.sv
// pkt_sfifo: single-clock FIFO with first-word-fall-through head and almost_full/overflow flags.
// Define PKT_SFIFO_STORE_FWD_EN for store-and-forward packet commit/drop.
module pkt_sfifo #(
    parameter int DATA_WIDTH   = 36,
    parameter int ADDR_WIDTH   = 9,
    parameter int AFULL_THRESH = (1 << ADDR_WIDTH) - 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  wr_eop,
    input  logic                  wr_drop,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  data_valid,
    output logic                  full,
    output logic                  almost_full,
    output logic                  empty,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  pkt_dropped,
    output logic [ADDR_WIDTH:0]   data_count
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_LVL  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_LVL = (ADDR_WIDTH + 1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] ONE       = (ADDR_WIDTH + 1)'(1);

    logic [1:0]            rst_sync_q, rst_sync_d;
    logic                  rst_int_n;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   occupancy;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  wr_ack_q, wr_ack_d, overflow_q, overflow_d, underflow_q, underflow_d;
    logic                  wr_acc, pop, drop;

    // Reset asserts asynchronously but releases two clocks after rst_n rises.
    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_int_n  = rst_sync_q[1];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rst_sync_q <= '0;
        else        rst_sync_q <= rst_sync_d;

    assign occupancy   = wr_ptr_q - rd_ptr_q;
    assign data_count  = commit_ptr_q - rd_ptr_q;
    assign full        = occupancy == FULL_LVL;
    assign almost_full = occupancy >= AFULL_LVL;
    assign empty       = data_count == '0;
    assign data_valid  = !empty;
    assign dout        = data_valid ? mem[rd_ptr_q[ADDR_WIDTH-1:0]] : dout_q;
    assign pop         = rd_en && data_valid;
    assign wr_acc      = wr_en && !full && !drop;
    assign wr_ack      = wr_ack_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

`ifdef PKT_SFIFO_STORE_FWD_EN
    logic bad_q, bad_d, pkt_dropped_q, pkt_dropped_d;
    // A packet that lost words to overflow is discarded when its eop arrives.
    assign drop        = wr_drop || (bad_q && wr_en && wr_eop);
    assign pkt_dropped = pkt_dropped_q;
`else
    logic unused_sf;
    assign drop        = 1'b0;
    assign pkt_dropped = 1'b0;
    assign unused_sf   = wr_eop ^ wr_drop;
`endif

    always_comb begin
        wr_ack_d      = wr_acc;
        overflow_d    = wr_en && full && !drop;
        underflow_d   = rd_en && !data_valid;
        rd_ptr_d      = pop ? rd_ptr_q + ONE : rd_ptr_q;
        dout_d        = dout;
        wr_ptr_d      = drop ? commit_ptr_q : wr_acc ? wr_ptr_q + ONE : wr_ptr_q;
`ifdef PKT_SFIFO_STORE_FWD_EN
        commit_ptr_d  = (wr_acc && wr_eop) ? wr_ptr_d : commit_ptr_q;
        bad_d         = drop ? 1'b0 : (overflow_d && wr_ptr_q != commit_ptr_q) ? 1'b1 : bad_q;
        pkt_dropped_d = drop;
`else
        commit_ptr_d  = wr_ptr_d;
`endif
    end

    always_ff @(posedge clk or negedge rst_int_n)
        if (!rst_int_n) begin
            wr_ptr_q      <= '0;
            commit_ptr_q  <= '0;
            rd_ptr_q      <= '0;
            dout_q        <= '0;
            wr_ack_q      <= 1'b0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
`ifdef PKT_SFIFO_STORE_FWD_EN
            bad_q         <= 1'b0;
            pkt_dropped_q <= 1'b0;
`endif
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            commit_ptr_q  <= commit_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            dout_q        <= dout_d;
            wr_ack_q      <= wr_ack_d;
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
`ifdef PKT_SFIFO_STORE_FWD_EN
            bad_q         <= bad_d;
            pkt_dropped_q <= pkt_dropped_d;
`endif
        end

    always_ff @(posedge clk)
        if (wr_acc) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= din;
endmodule
